// File: rtl/wt_cache_pkg.sv
// Shared types and constants for the write-through cache and its posted-write buffer.
// Word-granular addressing: byte offset bits below WORD_ADDR_LSB never take part in a match.
package wt_cache_pkg;

  localparam int CACHE_ADDR_W  = 32;
  localparam int CACHE_DATA_W  = 32;
  localparam int WORD_ADDR_LSB = 2;

  typedef struct packed {
    logic [CACHE_ADDR_W-1:0] addr;
    logic [CACHE_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_SEND = 1'b1
  } wb_state_e;

  function automatic logic same_word(input logic [CACHE_ADDR_W-1:0] a,
                                     input logic [CACHE_ADDR_W-1:0] b);
    return a[CACHE_ADDR_W-1:WORD_ADDR_LSB] == b[CACHE_ADDR_W-1:WORD_ADDR_LSB];
  endfunction

endpackage

// File: rtl/wb_match_unit.sv
// Combinational youngest-match search over the occupied window of the write buffer.
// Entries are scanned oldest to youngest so the last hit found is the youngest.
module wb_match_unit
  import wt_cache_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  wb_entry_t               entries_i [DEPTH],
  input  logic [PTR_W-1:0]        head_i,
  input  logic [PTR_W:0]          count_i,
  input  logic                    skip_head_i,
  input  logic [CACHE_ADDR_W-1:0] addr_i,
  output logic                    hit_o,
  output logic [PTR_W-1:0]        idx_o,
  output logic [CACHE_DATA_W-1:0] data_o
);

  logic [PTR_W-1:0] idx;

  // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    data_o = '0;
    idx    = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if (k < int'(count_i) && !(skip_head_i && k == 0) &&
          same_word(entries_i[idx].addr, addr_i)) begin
        hit_o  = 1'b1;
        idx_o  = idx;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/wt_write_buffer.sv
// Posted-write FIFO between the write-through cache and memory, with read forwarding.
// Define WB_COALESCE_EN to merge repeated stores to the same word into one non-head entry.
module wt_write_buffer
  import wt_cache_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_match,
  output logic [DATA_W-1:0] rd_data,
  output logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full
);

  wb_entry_t        buf_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  wb_state_e        state_q, state_d;

  logic push, pop, alloc, merge;
  logic [PTR_W-1:0] fwd_idx_unused;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign wr_ready  = !full;
  assign mem_valid = (state_q == WB_SEND);
  assign mem_addr  = mem_valid ? buf_q[head_q].addr : '0;
  assign mem_data  = mem_valid ? buf_q[head_q].data : '0;

  assign push  = wr_valid && wr_ready;
  assign pop   = mem_valid && mem_ack;
  assign alloc = push && !merge;

  wb_match_unit #(.DEPTH(DEPTH)) u_fwd (
    .entries_i   (buf_q),
    .head_i      (head_q),
    .count_i     (count_q),
    .skip_head_i (1'b0),
    .addr_i      (rd_addr),
    .hit_o       (rd_match),
    .idx_o       (fwd_idx_unused),
    .data_o      (rd_data)
  );

`ifdef WB_COALESCE_EN
  logic             merge_hit;
  logic [PTR_W-1:0] merge_idx;
  logic [DATA_W-1:0] merge_data_unused;

  // An in-flight head may already be on the memory bus, so it is never rewritten.
  wb_match_unit #(.DEPTH(DEPTH)) u_merge (
    .entries_i   (buf_q),
    .head_i      (head_q),
    .count_i     (count_q),
    .skip_head_i (state_q == WB_SEND),
    .addr_i      (wr_addr),
    .hit_o       (merge_hit),
    .idx_o       (merge_idx),
    .data_o      (merge_data_unused)
  );

  assign merge = push && merge_hit;
`else
  assign merge = 1'b0;
`endif

  assign count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE: if (count_d != '0) state_d = WB_SEND;
      WB_SEND: if (pop && count_d == '0) state_d = WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= WB_IDLE;
    end else begin
      if (alloc) tail_q <= tail_q + 1'b1;
      if (pop)   head_q <= head_q + 1'b1;
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // NOTE: entry storage has no reset; occupancy is tracked by count_q and the outputs are gated by state.
  always_ff @(posedge clk) begin
    if (alloc) begin
      buf_q[tail_q].addr <= {wr_addr[ADDR_W-1:WORD_ADDR_LSB], WORD_ADDR_LSB'(0)};
      buf_q[tail_q].data <= wr_data;
    end
`ifdef WB_COALESCE_EN
    if (merge) buf_q[merge_idx].data <= wr_data;
`endif
  end

endmodule

// File: tb/tb_wt_write_buffer.sv
// Directed self-checking bench for wt_write_buffer; expectations are hand-computed constants.
// Build with +define+WB_COALESCE_EN to exercise store merging instead of plain allocation.
module tb_wt_write_buffer;

  logic        clk, reset;
  logic        wr_valid, wr_ready, rd_match, mem_valid, mem_ack, empty, full;
  logic [31:0] wr_addr, wr_data, rd_addr, rd_data, mem_addr, mem_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [31:0] mon_addr [$];
  logic [31:0] mon_data [$];

  wt_write_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_match  (rd_match),
    .rd_data   (rd_data),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ack   (mem_ack),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset === 1'b1 && mem_valid === 1'b1 && mem_ack === 1'b1) begin
      mon_addr.push_back(mem_addr);
      mon_data.push_back(mem_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0; mem_ack = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    checks++; if (wr_ready  !== 1'b1)  begin errors++; $display("FAIL reset_wr_ready: got %b exp 1", wr_ready); end
    checks++; if (empty     !== 1'b1)  begin errors++; $display("FAIL reset_empty: got %b exp 1", empty); end
    checks++; if (mem_valid !== 1'b0)  begin errors++; $display("FAIL reset_mem_valid: got %b exp 0", mem_valid); end
    checks++; if (count     !== 3'd0)  begin errors++; $display("FAIL reset_count: got %0d exp 0", count); end
    checks++; if (full      !== 1'b0)  begin errors++; $display("FAIL reset_full: got %b exp 0", full); end
    checks++; if (mem_addr  !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
    checks++; if (mem_data  !== 32'h0) begin errors++; $display("FAIL reset_mem_data: got %h exp 0", mem_data); end
    checks++; if (rd_match  !== 1'b0)  begin errors++; $display("FAIL reset_rd_match: got %b exp 0", rd_match); end
    checks++; if (rd_data   !== 32'h0) begin errors++; $display("FAIL reset_rd_data: got %h exp 0", rd_data); end
  endtask

  task automatic test_basic_drain();
    int base = mon_addr.size();
    mem_ack = 1'b0;
    wr_valid = 1'b1; wr_addr = 32'h04; wr_data = 32'hCAFEBABE;
    tick();
    wr_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL drain_count1: got %0d exp 1", count); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %b exp 1", c, mem_valid); end
      checks++; if (mem_addr !== 32'h04) begin errors++; $display("FAIL drain_addr[%0d]: got %h exp 00000004", c, mem_addr); end
      checks++; if (mem_data !== 32'hCAFEBABE) begin errors++; $display("FAIL drain_data[%0d]: got %h exp cafebabe", c, mem_data); end
      tick();
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count0: got %0d exp 0", count); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL drain_idle: got %b exp 0", mem_valid); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b exp 1", empty); end
    checks++; if (mon_addr.size() !== base + 1) begin errors++; $display("FAIL drain_mem_count: got %0d exp %0d", mon_addr.size(), base + 1); end
    else begin
      checks++; if (mon_addr[base] !== 32'h04 || mon_data[base] !== 32'hCAFEBABE)
        begin errors++; $display("FAIL drain_mem_entry: got %h/%h exp 00000004/cafebabe", mon_addr[base], mon_data[base]); end
    end
  endtask

  task automatic test_full_wrap();
    int base = mon_addr.size();
    logic [31:0] ea, ed;
    mem_ack = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_addr = 32'(i * 16); wr_data = 32'hD000_0000 | 32'(i * 16);
      tick();
    end
    wr_addr = 32'h40; wr_data = 32'hD000_0040;
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b exp 1", full); end
    checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready: got %b exp 0", wr_ready); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d exp 4", count); end
    tick();
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_no_push: got %0d exp 4", count); end
    mem_ack = 1'b1;
    tick();
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_pop_only: got %0d exp 3", count); end
    checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready_back: got %b exp 1", wr_ready); end
    tick();
    wr_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_push_pop: got %0d exp 3", count); end
    repeat (3) tick();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d exp 0", count); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL full_idle: got %b exp 0", mem_valid); end
    checks++; if (mon_addr.size() !== base + 5) begin errors++; $display("FAIL full_mem_count: got %0d exp %0d", mon_addr.size(), base + 5); end
    else begin
      for (int k = 0; k < 5; k++) begin
        ea = 32'(k * 16); ed = 32'hD000_0000 | 32'(k * 16);
        checks++; if (mon_addr[base+k] !== ea || mon_data[base+k] !== ed)
          begin errors++; $display("FAIL full_order[%0d]: got %h/%h exp %h/%h", k, mon_addr[base+k], mon_data[base+k], ea, ed); end
      end
    end
  endtask

  task automatic test_forwarding();
    int base = mon_addr.size();
    logic [31:0] exp_a [4];
    logic [31:0] exp_d [4];
    exp_a = '{32'h08, 32'h0C, 32'h08, 32'h1C};
    exp_d = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    mem_ack = 1'b0;
    wr_valid = 1'b1;
    wr_addr = 32'h08; wr_data = 32'h11111111; tick();
    wr_addr = 32'h0C; wr_data = 32'h22222222; tick();
    wr_addr = 32'h0A; wr_data = 32'h33333333; tick();
    wr_valid = 1'b0;
    rd_addr = 32'h08; #1;
    checks++; if (rd_match !== 1'b1 || rd_data !== 32'h33333333) begin errors++; $display("FAIL fwd_08: got %b/%h exp 1/33333333", rd_match, rd_data); end
    rd_addr = 32'h0C; #1;
    checks++; if (rd_match !== 1'b1 || rd_data !== 32'h22222222) begin errors++; $display("FAIL fwd_0c: got %b/%h exp 1/22222222", rd_match, rd_data); end
    rd_addr = 32'h0B; #1;
    checks++; if (rd_match !== 1'b1 || rd_data !== 32'h33333333) begin errors++; $display("FAIL fwd_0b: got %b/%h exp 1/33333333", rd_match, rd_data); end
    rd_addr = 32'h1C; #1;
    checks++; if (rd_match !== 1'b0 || rd_data !== 32'h0) begin errors++; $display("FAIL fwd_miss: got %b/%h exp 0/00000000", rd_match, rd_data); end
    wr_valid = 1'b1; wr_addr = 32'h1C; wr_data = 32'h44444444; #1;
    checks++; if (rd_match !== 1'b0) begin errors++; $display("FAIL fwd_same_cycle: got %b exp 0", rd_match); end
    tick();
    wr_valid = 1'b0;
    checks++; if (rd_match !== 1'b1 || rd_data !== 32'h44444444) begin errors++; $display("FAIL fwd_next_cycle: got %b/%h exp 1/44444444", rd_match, rd_data); end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fwd_count: got %0d exp 4", count); end
    mem_ack = 1'b1;
    repeat (4) tick();
    mem_ack = 1'b0;
    rd_addr = 32'h08; #1;
    checks++; if (rd_match !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL fwd_after_drain: got %b/%0d exp 0/0", rd_match, count); end
    checks++; if (mon_addr.size() !== base + 4) begin errors++; $display("FAIL fwd_mem_count: got %0d exp %0d", mon_addr.size(), base + 4); end
    else begin
      for (int k = 0; k < 4; k++) begin
        checks++; if (mon_addr[base+k] !== exp_a[k] || mon_data[base+k] !== exp_d[k])
          begin errors++; $display("FAIL fwd_mem[%0d]: got %h/%h exp %h/%h", k, mon_addr[base+k], mon_data[base+k], exp_a[k], exp_d[k]); end
      end
    end
  endtask

`ifdef WB_COALESCE_EN
  task automatic test_coalesce();
    int base = mon_addr.size();
    logic [31:0] exp_a [3];
    logic [31:0] exp_d [3];
    exp_a = '{32'h00, 32'h04, 32'h00};
    exp_d = '{32'h0, 32'hB, 32'hC};
    mem_ack = 1'b0;
    wr_valid = 1'b1;
    wr_addr = 32'h00; wr_data = 32'h0; tick();
    wr_addr = 32'h04; wr_data = 32'hA; tick();
    wr_addr = 32'h04; wr_data = 32'hB; tick();
    wr_valid = 1'b0;
    checks++; if (count !== 3'd2) begin errors++; $display("FAIL coal_count2: got %0d exp 2", count); end
    rd_addr = 32'h04; #1;
    checks++; if (rd_match !== 1'b1 || rd_data !== 32'hB) begin errors++; $display("FAIL coal_fwd: got %b/%h exp 1/0000000b", rd_match, rd_data); end
    wr_valid = 1'b1; wr_addr = 32'h00; wr_data = 32'hC; tick();
    wr_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL coal_head_no_merge: got %0d exp 3", count); end
    mem_ack = 1'b1;
    repeat (3) tick();
    mem_ack = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL coal_drained: got %0d exp 0", count); end
    checks++; if (mon_addr.size() !== base + 3) begin errors++; $display("FAIL coal_mem_count: got %0d exp %0d", mon_addr.size(), base + 3); end
    else begin
      for (int k = 0; k < 3; k++) begin
        checks++; if (mon_addr[base+k] !== exp_a[k] || mon_data[base+k] !== exp_d[k])
          begin errors++; $display("FAIL coal_mem[%0d]: got %h/%h exp %h/%h", k, mon_addr[base+k], mon_data[base+k], exp_a[k], exp_d[k]); end
      end
    end
  endtask
`else
  task automatic test_no_coalesce();
    int base = mon_addr.size();
    mem_ack = 1'b0;
    wr_valid = 1'b1;
    wr_addr = 32'h00; wr_data = 32'h0; tick();
    wr_addr = 32'h04; wr_data = 32'hA; tick();
    wr_addr = 32'h04; wr_data = 32'hB; tick();
    wr_valid = 1'b0;
    checks++; if (count !== 3'd3) begin errors++; $display("FAIL nocoal_count: got %0d exp 3", count); end
    rd_addr = 32'h04; #1;
    checks++; if (rd_match !== 1'b1 || rd_data !== 32'hB) begin errors++; $display("FAIL nocoal_fwd: got %b/%h exp 1/0000000b", rd_match, rd_data); end
    mem_ack = 1'b1;
    repeat (3) tick();
    mem_ack = 1'b0;
    checks++; if (mon_addr.size() !== base + 3) begin errors++; $display("FAIL nocoal_mem_count: got %0d exp %0d", mon_addr.size(), base + 3); end
    else begin
      checks++; if (mon_data[base+1] !== 32'hA || mon_data[base+2] !== 32'hB)
        begin errors++; $display("FAIL nocoal_mem_data: got %h,%h exp 0000000a,0000000b", mon_data[base+1], mon_data[base+2]); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int base;
    mem_ack = 1'b0;
    wr_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_addr = 32'h100 + 32'(i * 4); wr_data = 32'hE000_0000 + 32'(i); tick();
    end
    wr_valid = 1'b0;
    checks++; if (mem_valid !== 1'b1 || count !== 3'd3) begin errors++; $display("FAIL rstmid_pre: got %b/%0d exp 1/3", mem_valid, count); end
    base = mon_addr.size();
    reset = 1'b0; #1;
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b exp 0", mem_valid); end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL rstmid_count: got %0d/%b exp 0/1", count, empty); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rstmid_addr: got %h exp 0", mem_addr); end
    tick();
    reset = 1'b1; mem_ack = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL rstmid_quiet[%0d]: got %b exp 0", c, mem_valid); end
    end
    mem_ack = 1'b0;
    checks++; if (mon_addr.size() !== base) begin errors++; $display("FAIL rstmid_mem: got %0d exp %0d", mon_addr.size(), base); end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_full_wrap();
    test_forwarding();
`ifdef WB_COALESCE_EN
    test_coalesce();
`else
    test_no_coalesce();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
